// File: rtl/interval_timer.sv
// Programmable interval timer counting microsecond, millisecond, second or clk ticks.
// It runs one-shot or auto-reload and keeps sticky expired/overrun flags.
module interval_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 usecond_pulse,
    input  logic                 msecond_pulse,
    input  logic                 second_pulse,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [1:0]           timebase,
    input  logic                 periodic,
    input  logic                 stop,
    input  logic                 ack,
    output logic [CNT_WIDTH-1:0] remaining,
    output logic                 running,
    output logic                 expire_pulse,
    output logic                 expired,
    output logic                 overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] remaining_nxt;
    logic [CNT_WIDTH-1:0] period_q, period_nxt;
    logic [1:0]           timebase_q, timebase_nxt;
    logic                 periodic_q, periodic_nxt;
    logic                 expire_nxt, expired_nxt, overrun_nxt;
    logic                 tick;

    // Only the latched source is looked at, so coincident strobes give one tick at most.
    always_comb begin
        tick = 1'b0;
        case (timebase_q)
            2'd0:    tick = usecond_pulse;
            2'd1:    tick = msecond_pulse;
            2'd2:    tick = second_pulse;
            default: tick = 1'b1;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt     = state;
        remaining_nxt = remaining;
        period_nxt    = period_q;
        timebase_nxt  = timebase_q;
        periodic_nxt  = periodic_q;
        expire_nxt    = 1'b0;
        expired_nxt   = expired;
        overrun_nxt   = overrun;

        if (load) begin
            if (period != '0) begin
                remaining_nxt = period;
                period_nxt    = period;
                timebase_nxt  = timebase;
                periodic_nxt  = periodic;
                state_nxt     = RUN;
            end else begin
                remaining_nxt = '0;
                state_nxt     = IDLE;
            end
        end else if (stop) begin
            state_nxt = IDLE;
        end else if (state == RUN && tick) begin
            if (remaining > ONE) begin
                remaining_nxt = remaining - ONE;
            end else if (remaining == ONE) begin
                expire_nxt = 1'b1;
                if (periodic_q) begin
                    remaining_nxt = period_q;
                end else begin
                    remaining_nxt = '0;
                    state_nxt     = IDLE;
                end
            end
        end

        // A same-edge expiry beats ack for expired, while ack always clears overrun.
        if (ack) begin
            expired_nxt = expire_nxt;
            overrun_nxt = 1'b0;
        end else if (expire_nxt) begin
            expired_nxt = 1'b1;
            overrun_nxt = overrun | expired;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            period_q     <= '0;
            timebase_q   <= 2'd0;
            periodic_q   <= 1'b0;
            expire_pulse <= 1'b0;
            expired      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nxt;
            remaining    <= remaining_nxt;
            period_q     <= period_nxt;
            timebase_q   <= timebase_nxt;
            periodic_q   <= periodic_nxt;
            expire_pulse <= expire_nxt;
            expired      <= expired_nxt;
            overrun      <= overrun_nxt;
        end
    end

    assign running = (state == RUN);

endmodule
